id_scoreboard: RTL and testbench

Register-dependency scoreboard and issue controller for the ID stage. It tracks the number of in-flight writes to each general register, from ID issue to WB retire. It drives the ID stage ready signal so that an instruction leaves ID only when its source operands are architecturally written and its destination write count has room. It also keeps a stall-cycle counter and a sticky error flag for bench and debug use.

---
 rtl/id_scoreboard.sv | 116 +++++++++++
 tb/tb_id_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register in-flight write tracking between ID issue and WB retire.
// Gates the ID ready signal on RAW hazards (busy sources) and on a full destination
// counter, and keeps a saturating stall-cycle counter plus a sticky underflow flag.
module id_scoreboard #(
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic               id_src1_en,
    input  logic [4:0]         id_src1,
    input  logic               id_src2_en,
    input  logic [4:0]         id_src2,
    input  logic               id_dst_we,
    input  logic [4:0]         id_dst,
    input  logic               ex_allow_in,
    input  logic               wb_we,
    input  logic [4:0]         wb_dst,
    output logic               id_ready_go,
    output logic               id_issue,
    output logic [31:0]        busy_mask,
    output logic [STALL_W-1:0] stall_cnt,
    output logic               sb_err
);

    localparam logic [CNT_W-1:0]   CntMax   = '1;
    localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);
    localparam logic [STALL_W-1:0] StallMax = '1;
    localparam logic [STALL_W-1:0] StallOne = STALL_W'(1);

    // Entry 0 exists only so that indexing by a 5-bit register number is uniform; it
    // is held at zero so r0 never reads as busy.
    logic [CNT_W-1:0]   cnt_q [32];
    logic [CNT_W-1:0]   cnt_d [32];
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;

    logic src1_haz, src2_haz, dst_haz;
    logic inc_en, ret_en, dec_en, underflow;

    // Hazard detection looks at registered counters only; a same-cycle WB retire
    // does not bypass into the ready decision.
    always_comb begin
        src1_haz    = id_src1_en & (id_src1 != 5'd0) & (cnt_q[id_src1] != '0);
        src2_haz    = id_src2_en & (id_src2 != 5'd0) & (cnt_q[id_src2] != '0);
        dst_haz     = id_dst_we & (id_dst != 5'd0) & (cnt_q[id_dst] == CntMax);
        id_ready_go = ~(src1_haz | src2_haz | dst_haz);
        id_issue    = id_valid & id_ready_go & ex_allow_in;
    end

    // Classify this cycle's counter events.
    always_comb begin
        inc_en    = id_issue & id_dst_we & (id_dst != 5'd0);
        ret_en    = wb_we & (wb_dst != 5'd0);
        dec_en    = ret_en & (cnt_q[wb_dst] != '0);
        underflow = ret_en & (cnt_q[wb_dst] == '0);
    end

    // Next-state counters: an increment and decrement on the same register cancel.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        cnt_d[0] = '0;
        for (int i = 1; i < 32; i++) begin
            logic inc_hit;
            logic dec_hit;
            inc_hit = inc_en & (id_dst == 5'(i));
            dec_hit = dec_en & (wb_dst == 5'(i));
            if (inc_hit && !dec_hit) begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end else if (dec_hit && !inc_hit) begin
                cnt_d[i] = cnt_q[i] - CntOne;
            end
        end
    end

    // Saturating hazard-stall counter and sticky underflow flag.
    always_comb begin
        stall_d = stall_q;
        if (id_valid && !id_ready_go && (stall_q != StallMax)) begin
            stall_d = stall_q + StallOne;
        end
        err_d = err_q | underflow;
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    // Busy bits are a pure decode of the counter flops, so they move only with them.
    always_comb begin
        busy_mask = '0;
        for (int i = 1; i < 32; i++) begin
            busy_mask[i] = (cnt_q[i] != '0);
        end
    end

    assign stall_cnt = stall_q;
    assign sb_err    = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
module tb_id_scoreboard;

    localparam int CNT_W   = 2;
    localparam int STALL_W = 16;
    localparam int MAXC    = (1 << CNT_W) - 1;
    localparam int MAXS    = (1 << STALL_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_src1_en, id_src2_en, id_dst_we, ex_allow_in, wb_we;
    logic [4:0] id_src1, id_src2, id_dst, wb_dst;
    logic id_ready_go, id_issue, sb_err;
    logic [31:0] busy_mask;
    logic [STALL_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Reference state: in-flight write count per register, stall cycles, error flag.
    int m_cnt [32];
    int m_stall;
    bit m_err;

    always #5 clk = ~clk;

    id_scoreboard #(.CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid),
        .id_src1_en(id_src1_en), .id_src1(id_src1),
        .id_src2_en(id_src2_en), .id_src2(id_src2),
        .id_dst_we(id_dst_we), .id_dst(id_dst),
        .ex_allow_in(ex_allow_in),
        .wb_we(wb_we), .wb_dst(wb_dst),
        .id_ready_go(id_ready_go), .id_issue(id_issue),
        .busy_mask(busy_mask), .stall_cnt(stall_cnt), .sb_err(sb_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        bit h1, h2, hd;
        h1 = id_src1_en && (id_src1 != 0) && (m_cnt[id_src1] > 0);
        h2 = id_src2_en && (id_src2 != 0) && (m_cnt[id_src2] > 0);
        hd = id_dst_we && (id_dst != 0) && (m_cnt[id_dst] >= MAXC);
        return !(h1 || h2 || hd);
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] > 0);
        return b;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_stall = 0;
        m_err   = 0;
    endtask

    task automatic drv(input bit v, input bit s1e, input int s1, input bit s2e, input int s2,
                       input bit we, input int d, input bit ex, input bit wwe, input int wd);
        id_valid = v;   id_src1_en = s1e; id_src1 = 5'(s1);
        id_src2_en = s2e; id_src2 = 5'(s2);
        id_dst_we = we; id_dst = 5'(d);  ex_allow_in = ex;
        wb_we = wwe;    wb_dst = 5'(wd);
    endtask

    // Let combinational outputs settle, then compare everything against the model.
    task automatic settle();
        #1;
        chk("ready", {31'd0, id_ready_go}, {31'd0, m_ready()});
        chk("issue", {31'd0, id_issue}, {31'd0, id_valid && m_ready() && ex_allow_in});
        chk("busy", busy_mask, m_busy());
        chk("stall", {16'd0, stall_cnt}, 32'(m_stall));
        chk("err", {31'd0, sb_err}, {31'd0, m_err});
    endtask

    // Advance one clock and apply the bookkeeping rules to the model.
    task automatic tick();
        bit rdy, iss;
        rdy = m_ready();
        iss = id_valid && rdy && ex_allow_in;
        @(posedge clk);
        if (wb_we && wb_dst != 0) begin
            if (m_cnt[wb_dst] == 0) m_err = 1;
            else m_cnt[wb_dst]--;
        end
        if (iss && id_dst_we && id_dst != 0) m_cnt[id_dst]++;
        if (id_valid && !rdy && m_stall < MAXS) m_stall++;
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    initial begin
        m_clear();
        reset = 1'b0;
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        #3;
        settle();
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_ready", {31'd0, id_ready_go}, 32'd1);
        chk("rst_issue", {31'd0, id_issue}, 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // Issue add.w r5.
        drv(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        settle();
        chk("r5_ready", {31'd0, id_ready_go}, 32'd1);
        chk("r5_issue", {31'd0, id_issue}, 32'd1);
        tick();

        // Reader of r5 stalls three cycles, then WB retires r5.
        drv(1, 1, 5, 0, 0, 0, 0, 1, 0, 0);
        settle();
        chk("r5_busy", busy_mask, 32'h0000_0020);
        chk("raw_ready", {31'd0, id_ready_go}, 32'd0);
        tick();
        cyc();
        cyc();
        drv(1, 1, 5, 0, 0, 0, 0, 1, 1, 5);
        settle();
        chk("stall3", {16'd0, stall_cnt}, 32'd3);
        chk("no_bypass", {31'd0, id_ready_go}, 32'd0);
        tick();
        drv(1, 1, 5, 0, 0, 0, 0, 1, 0, 0);
        settle();
        chk("r5_clear_ready", {31'd0, id_ready_go}, 32'd1);
        chk("r5_clear_busy", busy_mask, 32'h0);
        tick();

        // Back-pressure from EX alone is not a hazard stall.
        drv(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        cyc();
        cyc();
        drv(1, 0, 0, 0, 0, 1, 6, 1, 0, 0);
        settle();
        chk("ex_stall_uncounted", {16'd0, stall_cnt}, 32'd4);
        tick();

        // Simultaneous issue and retire of r7 keeps its count at 1.
        drv(1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
        cyc();
        drv(1, 0, 0, 0, 0, 1, 7, 1, 1, 7);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        settle();
        chk("r7_still_busy", busy_mask, 32'h0000_00C0);
        tick();
        // src2 hazard on r7, then retire it.
        drv(1, 0, 0, 1, 7, 0, 0, 1, 0, 0);
        settle();
        chk("src2_haz", {31'd0, id_ready_go}, 32'd0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
        cyc();

        // Fill r9 to the maximum, then a fourth writer must wait for a retire.
        drv(1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
        cyc();
        cyc();
        cyc();
        drv(1, 0, 0, 0, 0, 1, 9, 1, 1, 9);
        settle();
        chk("dst_full", {31'd0, id_ready_go}, 32'd0);
        tick();
        drv(1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
        settle();
        chk("dst_room_issue", {31'd0, id_issue}, 32'd1);
        tick();

        // r0 is never tracked; then an underflowing retire of r3.
        drv(1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        settle();
        chk("r0_ready", {31'd0, id_ready_go}, 32'd1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
        settle();
        chk("r0_busy", busy_mask, 32'h0000_0240);
        chk("err_before", {31'd0, sb_err}, 32'd0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        settle();
        chk("err_set", {31'd0, sb_err}, 32'd1);
        tick();
        cyc();

        // Make r4/r8 busy, stall to 10, then reset mid-cycle.
        drv(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
        cyc();
        drv(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
        cyc();
        drv(1, 1, 4, 0, 0, 0, 0, 1, 0, 0);
        cyc();
        cyc();
        cyc();
        cyc();
        settle();
        chk("stall10", {16'd0, stall_cnt}, 32'd10);
        #2;
        reset = 1'b0;
        #1;
        m_clear();
        chk("arst_busy", busy_mask, 32'h0);
        chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
        chk("arst_err", {31'd0, sb_err}, 32'd0);
        chk("arst_ready", {31'd0, id_ready_go}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        settle();
        chk("post_rst_issue", {31'd0, id_issue}, 32'd1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
